// File: rtl/more_than_one_one_pkg.sv
// Shared definitions for the "more than one 1 seen" detector.
package more_than_one_one_pkg;

  // Detector state; 2'b11 is unused and recovers to S_NONE.
  typedef enum logic [1:0] {
    S_NONE = 2'd0,
    S_ONE  = 2'd1,
    S_MANY = 2'd2
  } state_t;

endpackage : more_than_one_one_pkg

// File: rtl/more_than_one_one_if.sv
// Serial data / detect flag bundle used by whoever drives the detector.
interface more_than_one_one_if;

  logic i;
  logic y;

  // Source of serial data, observer of the flag.
  modport master (output i, input y);

  // Detector side.
  modport slave (input i, output y);

endinterface : more_than_one_one_if

// File: rtl/more_than_one_one.sv
// Moore FSM that raises y once two or more ones (not necessarily
// consecutive) have been sampled on i since the last synchronous reset.
module more_than_one_one
  import more_than_one_one_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i,
  output logic y
);

  state_t state_q;
  state_t state_d;

  // State register; synchronous reset wins over any input value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_NONE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and flag decode from the registered state only (y has no path from i).
  always_comb begin
    state_d = S_NONE;
    y       = 1'b0;
    case (state_q)
      S_NONE: state_d = i ? S_ONE : S_NONE;
      S_ONE:  state_d = i ? S_MANY : S_ONE;
      S_MANY: begin
        state_d = S_MANY;
        y       = 1'b1;
      end
      default: begin
        state_d = S_NONE;
        y       = 1'b0;
      end
    endcase
  end

endmodule : more_than_one_one

// File: tb/tb_more_than_one_one.sv
// Table-driven and hand-sequenced checks for more_than_one_one.
module tb_more_than_one_one;
  import more_than_one_one_pkg::*;

  logic clk;
  logic rst;

  more_than_one_one_if bus ();

  more_than_one_one dut (
    .clk (clk),
    .rst (rst),
    .i   (bus.i),
    .y   (bus.y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  rst;
    logic  i;
    logic  exp_y;
    string name;
  } vec_t;

  vec_t vecs[$];
  logic exp_q[$];
  string name_q[$];

  int unsigned checks;
  int unsigned errors;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  function automatic void add(input logic r, input logic d, input logic e, input string n);
    vec_t v;
    v.rst   = r;
    v.i     = d;
    v.exp_y = e;
    v.name  = n;
    vecs.push_back(v);
  endfunction

  // Drive one cycle's inputs at the falling edge, queue the expectation,
  // then compare after the rising edge that samples them.
  task automatic step(input logic r, input logic d, input logic e, input string n);
    logic  exp_y;
    string nm;
    @(negedge clk);
    rst   = r;
    bus.i = d;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
    exp_y = exp_q.pop_front();
    nm    = name_q.pop_front();
    checks++;
    if (bus.y !== exp_y) begin
      errors++;
      $display("FAIL %s: y got %b required %b", nm, bus.y, exp_y);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    bus.i  = 1'b0;

    // Reset then idle zeros.
    add(1, 0, 0, "rst_hold0");
    add(1, 0, 0, "rst_hold1");
    for (int k = 0; k < 5; k++) add(0, 0, 0, "idle_zero");
    // Sparse ones 0,1,0,0,1,1,1,0.
    add(1, 0, 0, "rst_a");
    add(0, 0, 0, "seq_b0");
    add(0, 1, 0, "seq_b1");
    add(0, 0, 0, "seq_b2");
    add(0, 0, 0, "seq_b3");
    add(0, 1, 1, "seq_b4_second_one");
    add(0, 1, 1, "seq_b5");
    add(0, 1, 1, "seq_b6");
    add(0, 0, 1, "seq_b7_hold");
    // Back-to-back ones.
    add(1, 0, 0, "rst_b");
    add(0, 1, 0, "b2b_first");
    add(0, 1, 1, "b2b_second");
    add(0, 0, 1, "many_absorb0");
    // Reset with i=1 has priority; history discarded.
    add(1, 1, 0, "rst_prio");
    add(0, 1, 0, "after_rst_one");
    add(0, 1, 1, "after_rst_two");
    // Reset held with i=1 keeps y low.
    add(1, 1, 0, "rst_held0");
    add(1, 1, 0, "rst_held1");
    add(1, 1, 0, "rst_held2");
    add(0, 0, 0, "rst_release");

    foreach (vecs[k]) step(vecs[k].rst, vecs[k].i, vecs[k].exp_y, vecs[k].name);

    // Single one then 20 zeros stays low; state still S_ONE, so one more 1 fires.
    step(1, 0, 0, "one_rst");
    step(0, 1, 0, "one_first");
    for (int k = 0; k < 20; k++) step(0, 0, 0, "one_zeros");
    step(0, 1, 1, "one_then_second");

    // Reset from S_ONE discards the pending one.
    step(1, 0, 0, "rst_from_one_pre");
    step(0, 1, 0, "rst_from_one_a");
    step(1, 0, 0, "rst_from_one_rst");
    step(0, 1, 0, "rst_from_one_b");
    step(0, 1, 1, "rst_from_one_c");

    // Illegal encoding: y low, recovers to S_NONE even with i=1.
    @(negedge clk);
    rst   = 1'b0;
    bus.i = 1'b1;
    force dut.state_q = state_t'(2'd3);
    #1;
    checks++;
    if (bus.y !== 1'b0) begin
      errors++;
      $display("FAIL illegal_y: y got %b required 0", bus.y);
    end
    release dut.state_q;
    @(posedge clk);
    #1;
    checks++;
    if (dut.state_q !== S_NONE) begin
      errors++;
      $display("FAIL illegal_next: state got %0d required %0d", dut.state_q, S_NONE);
    end
    checks++;
    if (bus.y !== 1'b0) begin
      errors++;
      $display("FAIL illegal_after_y: y got %b required 0", bus.y);
    end
    step(0, 1, 0, "illegal_then_one");
    step(0, 1, 1, "illegal_then_two");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_more_than_one_one

// File: doc/more_than_one_one.md
MORE_THAN_ONE_ONE -- requirements
Module: more_than_one_one

Interface
REQ-001 The module SHALL have no parameters; the detection threshold SHALL be fixed at two ones.
REQ-002 The port list SHALL be, in order: clk, rst, i, y.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 i  input  1  serial data bit, sampled on each rising edge of clk.
REQ-006 y  output  1  registered detect flag; 1 SHALL mean that more than one 1 has been sampled on i since the last reset.

Function
REQ-007 The block SHALL be a Moore FSM with three states: S_NONE (no ones seen), S_ONE (exactly one 1 seen) and S_MANY (two or more ones seen).
REQ-008 From S_NONE: i=1 SHALL go to S_ONE; i=0 SHALL stay in S_NONE.
REQ-009 From S_ONE: i=1 SHALL go to S_MANY; i=0 SHALL stay in S_ONE.
REQ-010 The ones need not be consecutive; any number of zeros between them SHALL be allowed.
REQ-011 S_MANY SHALL be absorbing: it SHALL be held for any value of i until rst is asserted.
REQ-012 y SHALL be 1 only in S_MANY and SHALL be 0 in S_NONE and S_ONE.
REQ-013 y SHALL be decoded from the state register only, with no combinational path from i to y.
REQ-014 Latency: y SHALL rise on the same rising edge that samples the second 1, i.e. it is visible in the cycle after the second 1 is presented.
REQ-015 y SHALL be 0 while i is held at 0 from reset indefinitely.
REQ-016 Unused state encodings SHALL transition to S_NONE on the next edge, and y SHALL be 0 in them.

Reset
REQ-017 When rst=1 at a rising edge, the state SHALL become S_NONE and y SHALL be 0 after that edge, whatever the value of i.
REQ-018 rst SHALL have priority over i when both are asserted on the same edge; a 1 on i at that edge SHALL NOT be counted.
REQ-019 Reset mid-operation, from S_ONE or S_MANY, SHALL discard all history; counting SHALL restart from zero after rst deasserts.
REQ-020 While rst is held at 1 across several edges, y SHALL remain 0.
REQ-021 There SHALL be no asynchronous reset path.

Structure
REQ-022 A shared package SHALL hold the state enum typedef (S_NONE, S_ONE, S_MANY) with a 2-bit encoding.
REQ-023 The implementation SHALL be a single module with no sub-modules.
REQ-024 The implementation SHALL use one sequential process for the state register and one combinational process for next state and output decode.

Verification
REQ-025 rst=1 for 2 edges, then rst=0 with i=0 for 5 edges -> y=0 throughout.
REQ-026 After reset, i sequence 0,1,0,0,1,1,1,0 -> y=0 until the edge sampling the 5th bit (the second 1), then y=1 and held through the remaining bits.
REQ-027 After reset, i=1,1 -> y=0 after edge 1 and y=1 after edge 2.
REQ-028 Reach S_MANY, then rst=1 for 1 edge with i=1 -> y=0 after that edge; then i=1 once -> y stays 0; then i=1 again -> y=1.
REQ-029 After reset, a single 1 followed by 20 zeros -> y=0 throughout, and the state remains S_ONE.
REQ-030 Force an illegal state encoding with i=1 -> y=0, and the next state is S_NONE.
